stream_n_samples: RTL
=====================

# stream_n_samples

Playback-side counterpart to the microphone window capture path. Accepts a complete window of `SAMPLES` words in one parallel transfer, then streams the words out one at a time, oldest first (index 0 first), over a valid/ready interface. Output rate is paced to at most one word per `PERIOD` clocks, matching the converter sample rate. Sits between the window-producing logic and a serial sink such as a DAC/speaker driver or a per-sample processing stage.

## Interface
- `SAMPLES`, 16: words per window; must be ≥ 2.
- `WIDTH`, 32: bits per sample word.
- `PERIOD`, 4: minimum clocks between consecutive output handshakes; must be ≥ 1.

- `clk`  in  1  single clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `win_valid`  in  1  `win_data` holds a full window.
- `win_ready`  out  1  block can capture a window this cycle.
- `win_data`  in  `WIDTH` × `SAMPLES` (unpacked array `[SAMPLES-1:0]`)  window; element 0 is played first.
- `out_valid`  out  1  `out_data` is presented.
- `out_ready`  in  1  sink accepts `out_data` this cycle.
- `out_data`  out  `WIDTH`  current sample.
- `out_index`  out  `$clog2(SAMPLES)`  position of `out_data` within its window.
- `out_last`  out  1  high with `out_valid` when `out_index == SAMPLES-1`.
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation
- States:
  - IDLE: `win_ready = 1`.
  - PRESENT: `out_valid = 1`.
  - GAP: pacing wait. Nothing asserted.
  - DRAIN: pacing wait after the last word. `win_ready = 0`.
- IDLE:
  - On `win_valid && win_ready`, capture all `SAMPLES` words into an internal buffer.
  - Set index to 0 and go to PRESENT.
  - `win_data` is ignored in every other cycle and state.
- PRESENT:
  - `out_data = buf[index]`, `out_index = index`, `out_last = (index == SAMPLES-1)`.
  - All three hold stable while `out_valid && !out_ready`. No timeout.
- Handshake (`out_valid && out_ready`) in PRESENT, when not last:
  - Increment index.
  - Go to PRESENT directly if `PERIOD == 1`, otherwise go to GAP.
- Handshake on the last word:
  - Go to IDLE directly if `PERIOD == 1`, otherwise go to DRAIN.
- GAP and DRAIN:
  - Last for exactly `PERIOD-1` cycles, counted from the cycle after the handshake.
  - GAP exits to PRESENT; DRAIN exits to IDLE.
- Index never wraps within a window. A new window always restarts at index 0.
- The buffer is held until the next capture. Upstream may change `win_data` freely after the capture cycle.
- `out_data` is 0 in every state except PRESENT, so a stale sample is never visible.

## Timing
- Reset: on any clock edge with `reset = 1`, go to IDLE.
  - Outputs from the next cycle: `out_valid = 0`, `out_data = 0`, `out_index = 0`, `out_last = 0`, `busy = 0`, `win_ready = 1`.
  - Reset mid-window discards the remaining samples. Reset has priority over a simultaneous capture or output handshake.
- Capture in cycle c: `out_valid = 1` with index 0 from cycle c+1. Latency is 1 clock.
- Non-last handshake in cycle t: `out_valid = 0` in cycles t+1 … t+PERIOD-1, then `out_valid = 1` with the next index in cycle t+PERIOD.
- Last handshake in cycle t: `win_ready = 1` from cycle t+PERIOD. For `PERIOD = 1` this is cycle t+1.
  - The earliest next capture is therefore t+PERIOD, and the earliest next `out_valid` is t+PERIOD+1.
- Sink stall of k cycles delays everything after it by exactly k cycles. No sample is dropped or duplicated.
- `win_ready` and `out_valid` are never high in the same cycle.
- Minimum window throughput: one window per `SAMPLES·PERIOD + 1` clocks with `out_ready` held at 1.
- All outputs are driven from registered state and buffer.
- `out_ready` must not combinationally affect `out_valid`, `out_data`, `out_index` or `out_last` in the same cycle.

## Test plan
- Reset then basic stream:
  - Setup: SAMPLES=4, WIDTH=8, PERIOD=1. Window {0x11,0x22,0x33,0x44}. `out_ready` held at 1.
  - Required: capture at cycle c; `out_data` 0x11..0x44 in cycles c+1..c+4; `out_last` only at c+4; `win_ready = 1` at c+5.
- Pacing:
  - Setup: PERIOD=4, `out_ready` held at 1.
  - Required: successive handshakes exactly 4 cycles apart; `out_valid` low for 3 cycles between them; `win_ready` rises 4 cycles after the last handshake.
- Backpressure:
  - Stimulus: drop `out_ready` for 5 cycles while index 2 is presented.
  - Required: `out_data`, `out_index = 2` and `out_last = 0` hold stable; all 4 words delivered exactly once, in order.
- Capture isolation:
  - Stimulus: change `win_data` every cycle after capture; hold `win_valid` high throughout.
  - Required: the output reproduces the captured window exactly; no second capture until `win_ready` rises.
- Reset mid-window:
  - Stimulus: assert `reset` for 1 cycle while index 1 is in PRESENT.
  - Required: next cycle `out_valid = 0`, `out_index = 0`, `win_ready = 1`; a new window then streams from index 0.
- Back-to-back windows:
  - Setup: PERIOD=2. Two windows offered continuously.
  - Required: 9 clocks from first capture to second capture; second window starts at index 0 with no leftover words from the first.

Source files
------------

// File: rtl/stream_n_samples_if.sv
// ---------------------------------------------------------------------------
// stream_n_samples_if
// Bundles the two handshakes of the window player: the parallel window
// capture side (win_*) and the serial playback side (out_*).
//
//   win_valid  producer -> player   win_data holds a complete window
//   win_ready  player -> producer   player can take a window this cycle
//   win_data   producer -> player   SAMPLES words, element 0 played first
//   out_valid  player -> sink       out_data is presented
//   out_ready  sink -> player       sink accepts out_data this cycle
//   out_data   player -> sink       current sample word
//   out_index  player -> sink       position of out_data within its window
//   out_last   player -> sink       final word of the window
//
// The master modport is the environment side (window producer plus sink);
// the slave modport is the player itself.
// ---------------------------------------------------------------------------
interface stream_n_samples_if #(
   parameter int SAMPLES = 16,
   parameter int WIDTH   = 32
);

   logic                       win_valid;
   logic                       win_ready;
   logic [WIDTH-1:0]           win_data [SAMPLES-1:0];
   logic                       out_valid;
   logic                       out_ready;
   logic [WIDTH-1:0]           out_data;
   logic [$clog2(SAMPLES)-1:0] out_index;
   logic                       out_last;

   modport master (
      output win_valid,
      output win_data,
      output out_ready,
      input  win_ready,
      input  out_valid,
      input  out_data,
      input  out_index,
      input  out_last
   );

   modport slave (
      input  win_valid,
      input  win_data,
      input  out_ready,
      output win_ready,
      output out_valid,
      output out_data,
      output out_index,
      output out_last
   );

endinterface

// File: rtl/stream_n_samples.sv
// ---------------------------------------------------------------------------
// stream_n_samples
// Playback side of the microphone window path. A whole window of SAMPLES
// words is taken in one parallel transfer and then played out one word at a
// time, index 0 first, with at least PERIOD clocks between consecutive
// output handshakes so the sink sees the converter sample rate.
//
// Ports:
//   clk    single clock, everything on the rising edge
//   reset  synchronous, active-high; returns the player to IDLE
//   sif    stream_n_samples_if.slave (window capture + sample output)
//   busy   high whenever the player is not idle
//
// Parameters:
//   SAMPLES  words per window (>= 2)
//   WIDTH    bits per sample word
//   PERIOD   minimum clocks between output handshakes (>= 1)
// ---------------------------------------------------------------------------
module stream_n_samples #(
   parameter int SAMPLES = 16,
   parameter int WIDTH   = 32,
   parameter int PERIOD  = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   stream_n_samples_if.slave     sif,
   output logic                  busy
);

   localparam int IDX_W = $clog2(SAMPLES);

   // The pacing counter only ever holds PERIOD-2 down to 0, so it is sized
   // for PERIOD-2; a 1-bit counter is kept for the short PERIOD cases so the
   // declaration stays legal even where the wait states are never entered.
   localparam int CNT_W = (PERIOD > 2) ? $clog2(PERIOD - 1) : 1;

   localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'((PERIOD > 1) ? (PERIOD - 2) : 0);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SAMPLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      PRESENT,
      GAP,
      DRAIN
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [IDX_W-1:0] idx;
   logic [IDX_W-1:0] idx_next;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_next;
   logic [WIDTH-1:0] win_buf [SAMPLES-1:0];
   logic             capture;
   logic             at_last;

   // win_ready is simply "in IDLE", so a capture is any cycle in IDLE where
   // the producer offers a window.
   assign capture = (state == IDLE) && sif.win_valid;
   assign at_last = (idx == LAST_IDX);

   // State, index and pacing counter registers. Reset is synchronous and
   // wins over whatever the next-state logic asked for in the same cycle,
   // which is how a capture or handshake coinciding with reset is dropped.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         idx   <= '0;
         cnt   <= '0;
      end else begin
         state <= state_next;
         idx   <= idx_next;
         cnt   <= cnt_next;
      end
   end

   // Window buffer. It is written only on a capture, so the upstream logic
   // is free to change win_data on any later cycle. The buffer is not reset
   // because out_data is forced to zero outside PRESENT, so stale contents
   // are never visible.
   always_ff @(posedge clk) begin
      if (capture && !reset) begin
         win_buf <= sif.win_data;
      end
   end

   // Next-state logic. PRESENT holds until the sink takes the word; the
   // handshake then either moves to the next word (through GAP when pacing
   // is needed) or finishes the window (through DRAIN when pacing is
   // needed). The counter is loaded with PERIOD-2 on the handshake so the
   // wait state lasts exactly PERIOD-1 cycles including the cycle it exits
   // on. With PERIOD == 1 the wait states are skipped entirely.
   always_comb begin
      state_next = state;
      idx_next   = idx;
      cnt_next   = cnt;
      case (state)
         IDLE: begin
            if (sif.win_valid) begin
               idx_next   = '0;
               state_next = PRESENT;
            end
         end
         PRESENT: begin
            if (sif.out_ready) begin
               cnt_next = GAP_LOAD;
               if (at_last) begin
                  if (PERIOD == 1) begin
                     state_next = IDLE;
                  end else begin
                     state_next = DRAIN;
                  end
               end else begin
                  idx_next = idx + IDX_W'(1);
                  if (PERIOD == 1) begin
                     state_next = PRESENT;
                  end else begin
                     state_next = GAP;
                  end
               end
            end
         end
         GAP: begin
            if (cnt == '0) begin
               state_next = PRESENT;
            end else begin
               cnt_next = cnt - CNT_W'(1);
            end
         end
         DRAIN: begin
            if (cnt == '0) begin
               state_next = IDLE;
            end else begin
               cnt_next = cnt - CNT_W'(1);
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Outputs are decoded purely from registered state and the buffer, so
   // out_ready never reaches them combinationally. Data, index and last are
   // all forced to zero outside PRESENT.
   always_comb begin
      sif.win_ready = (state == IDLE);
      sif.out_valid = (state == PRESENT);
      sif.out_data  = '0;
      sif.out_index = '0;
      sif.out_last  = 1'b0;
      busy          = (state != IDLE);
      if (state == PRESENT) begin
         sif.out_data  = win_buf[idx];
         sif.out_index = idx;
         sif.out_last  = at_last;
      end
   end

endmodule
